uart_rx: RTL and testbench

//  Receive side of the UART link; pairs with uart_tx (8N1, LSB first, idle-high line).

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_tick.sv | 27 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, frame constants and the
// oversample tick divisor calculation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per oversample tick, truncated; never below one so the tick still exists.
    function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversample);
        int d;
        d = clk_freq / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks,
// running continuously so idle and active frames share the same tick phase.
module uart_rx_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CW'(DIV - 1)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, validates the start bit at mid-bit and
// samples each data/stop bit mid-period on the oversample tick.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DIV    = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SCNT_W = $clog2(OVERSAMPLE);

    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    logic tick;
    logic rx_meta_reg, rx_s;

    rx_state_t         state_reg, state_next;
    logic [SCNT_W-1:0] scnt_reg, scnt_next;
    logic [2:0]        bcnt_reg, bcnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              ferr_reg, ferr_next;

    uart_rx_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchroniser resets high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            scnt_reg  <= '0;
            bcnt_reg  <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            scnt_reg  <= scnt_next;
            bcnt_reg  <= bcnt_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        scnt_next  = scnt_reg;
        bcnt_next  = bcnt_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    scnt_next  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt_reg == HALF_LAST) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                            scnt_next  = '0;
                            bcnt_next  = '0;
                        end
                    end else begin
                        scnt_next = scnt_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (scnt_reg == FULL_LAST) begin
                        shift_next[bcnt_reg] = rx_s;
                        scnt_next            = '0;
                        if (bcnt_reg == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            bcnt_next = bcnt_reg + 1'b1;
                        end
                    end else begin
                        scnt_next = scnt_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (scnt_reg == FULL_LAST) begin
                        if (rx_s) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                            state_next = IDLE;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = BREAK;
                        end
                    end else begin
                        scnt_next = scnt_reg + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign data      = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = ferr_reg;
    assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 32 clocks per bit: good frames, back-to-back,
// glitch, framing error, mid-frame reset and +/-3% line-rate offset.
module tb_uart_rx;

    localparam int CLK_FREQ   = 32_000_000;
    localparam int BAUD_RATE  = 1_000_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         ferr_cnt = 0;
    int         viol  = 0;
    logic [7:0] log_data[$];
    int         log_cyc[$];
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;

    always @(posedge clk) cyc++;

    // Record every strobe; flag strobes wider than one cycle or overlapping.
    always @(negedge clk) begin
        if (rx_valid) begin
            log_data.push_back(data);
            log_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if ((rx_valid && prev_v) || (frame_err && prev_f) || (rx_valid && frame_err)) viol++;
        prev_v = rx_valid;
        prev_f = frame_err;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_val);
        rx = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx = stop_val;
        repeat (bit_clks) @(negedge clk);
    endtask

    initial begin
        int         n0;
        int         f0;
        int         gap;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] partial;

        rx  = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_data", 32'(data), 32'h00);
        check_eq("rst_valid", 32'(rx_valid), 32'h0);
        check_eq("rst_ferr", 32'(frame_err), 32'h0);
        check_eq("rst_busy", 32'(rx_busy), 32'h0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 1: single good frame
        n0 = log_data.size();
        f0 = ferr_cnt;
        send_byte(8'hA5, BIT_CLKS, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t1_count", 32'(log_data.size() - n0), 32'd1);
        check_eq("t1_data", 32'(data), 32'hA5);
        check_eq("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_eq("t1_busy", 32'(rx_busy), 32'h0);

        // 2: back-to-back frames with no idle gap
        n0 = log_data.size();
        send_byte(8'h00, BIT_CLKS, 1'b1);
        send_byte(8'hFF, BIT_CLKS, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t2_count", 32'(log_data.size() - n0), 32'd2);
        d0  = (log_data.size() > n0)     ? log_data[n0]     : 8'h5E;
        d1  = (log_data.size() > n0 + 1) ? log_data[n0 + 1] : 8'h5E;
        gap = (log_cyc.size() > n0 + 1)  ? log_cyc[n0 + 1] - log_cyc[n0] : 0;
        check_eq("t2_first", 32'(d0), 32'h00);
        check_eq("t2_second", 32'(d1), 32'hFF);
        check_eq("t2_gap_ok", 32'(gap >= 316 && gap <= 324), 32'd1);

        // 3: short low glitch is rejected at mid start bit
        n0 = log_data.size();
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t3_busy_hi", 32'(rx_busy), 32'h1);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        check_eq("t3_busy_lo", 32'(rx_busy), 32'h0);
        check_eq("t3_valid", 32'(log_data.size() - n0), 32'd0);
        check_eq("t3_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 4: stop bit low then held low -> framing error, then recovery
        n0 = log_data.size();
        f0 = ferr_cnt;
        send_byte(8'h3C, BIT_CLKS, 1'b0);
        repeat (100) @(negedge clk);
        check_eq("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
        check_eq("t4_valid", 32'(log_data.size() - n0), 32'd0);
        check_eq("t4_data_kept", 32'(data), 32'hFF);
        check_eq("t4_busy_break", 32'(rx_busy), 32'h1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t4_busy_idle", 32'(rx_busy), 32'h0);
        n0 = log_data.size();
        send_byte(8'h81, BIT_CLKS, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t4_next_count", 32'(log_data.size() - n0), 32'd1);
        check_eq("t4_next_data", 32'(data), 32'h81);

        // 5: reset during bit 4 discards the partial word
        n0 = log_data.size();
        f0 = ferr_cnt;
        partial = 8'hC3;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx = partial[i];
            repeat ((i == 4) ? BIT_CLKS / 2 : BIT_CLKS) @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_rst_data", 32'(data), 32'h00);
        check_eq("t5_rst_valid", 32'(rx_valid), 32'h0);
        check_eq("t5_rst_ferr", 32'(frame_err), 32'h0);
        check_eq("t5_rst_busy", 32'(rx_busy), 32'h0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'h5A, BIT_CLKS, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t5_count", 32'(log_data.size() - n0), 32'd1);
        check_eq("t5_data", 32'(data), 32'h5A);
        check_eq("t5_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 6: line rate +3% slow (33 clk/bit) and -3% fast (31 clk/bit)
        n0 = log_data.size();
        f0 = ferr_cnt;
        send_byte(8'h55, 33, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t6_slow_count", 32'(log_data.size() - n0), 32'd1);
        check_eq("t6_slow_data", 32'(data), 32'h55);
        check_eq("t6_slow_ferr", 32'(ferr_cnt - f0), 32'd0);
        n0 = log_data.size();
        f0 = ferr_cnt;
        send_byte(8'h55, 31, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("t6_fast_count", 32'(log_data.size() - n0), 32'd1);
        check_eq("t6_fast_data", 32'(data), 32'h55);
        check_eq("t6_fast_ferr", 32'(ferr_cnt - f0), 32'd0);

        check_eq("strobe_width", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
